// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Instruction-fetch front end: PC, FWFT prefetch queue, redirect.
// Revision : 1.0
// ============================================================================
module fetch_queue #(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              BR_SHIFT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     halt,
    output logic [XLEN-1:0]          imem_addr,
    input  logic [ILEN-1:0]          imem_rdata,
    input  logic                     branch_taken,
    input  logic [XLEN-1:0]          branch_pc,
    input  logic [XLEN-1:0]          branch_offset,
    output logic                     inst_valid,
    output logic [ILEN-1:0]          inst,
    output logic [XLEN-1:0]          inst_pc,
    input  logic                     inst_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     misalign_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ILEN + XLEN;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            run_q, run_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;
    logic [EW-1:0]   mem_q [DEPTH];

    logic            push;
    logic            pop;
    logic [XLEN-1:0] target;
    logic [EW-1:0]   head;

    // halt takes effect on the edge where it is sampled, so it also gates push
    always_comb begin
        pop    = (count_q != '0) & inst_ready & ~branch_taken;
        push   = run_q & ~halt & ((count_q < CW'(DEPTH)) | pop) & ~branch_taken;
        target = branch_pc + (branch_offset << BR_SHIFT);

        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        err_d      = err_q;
        run_d      = run_q;

        if (halt) begin
            run_d = 1'b0;
        end else if (start && !err_q) begin
            run_d = 1'b1;
        end

        if (branch_taken) begin
            fetch_pc_d = target;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            if (target[1:0] != 2'b00) begin
                err_d = 1'b1;
                run_d = 1'b0;
            end
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PW'(1);
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            run_q      <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            run_q      <= run_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    // Storage needs no reset: outputs are masked whenever count is zero
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {imem_rdata, fetch_pc_q};
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign imem_addr    = fetch_pc_q;
    assign inst_valid   = (count_q != '0);
    assign inst         = inst_valid ? head[EW-1:XLEN] : '0;
    assign inst_pc      = inst_valid ? head[XLEN-1:0]  : '0;
    assign count        = count_q;
    assign misalign_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Directed vector table plus randomized run against a queue model.
// Revision : 1.0
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_pc = '0;
    logic [63:0] branch_offset = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic [2:0]  count;
    logic        misalign_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_queue #(.XLEN(64), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(64'h0), .BR_SHIFT(1)) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .branch_taken(branch_taken), .branch_pc(branch_pc), .branch_offset(branch_offset),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .count(count), .misalign_err(misalign_err)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'h1000_0000 + a[33:2];
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    // Reference model: a plain queue of fetched {inst, pc} pairs
    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
    } ent_t;

    ent_t        m_q[$];
    logic [63:0] m_pc  = '0;
    bit          m_run = 1'b0;
    bit          m_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit st, input bit hl, input bit rdy,
                        input bit br, input logic [63:0] bpc, input logic [63:0] boff);
        logic [63:0] tgt;
        bit          do_pop, do_push;
        ent_t        e;
        reset = rst; start = st; halt = hl; inst_ready = rdy;
        branch_taken = br; branch_pc = bpc; branch_offset = boff;

        if (!rst) begin
            m_q.delete(); m_pc = 64'h0; m_run = 1'b0; m_err = 1'b0;
        end else begin
            bit run_next;
            run_next = hl ? 1'b0 : ((st && !m_err) ? 1'b1 : m_run);
            if (br) begin
                tgt = bpc + (boff * 64'd2);
                m_q.delete();
                m_pc = tgt;
                if (tgt % 4 != 0) begin
                    m_err = 1'b1;
                    run_next = 1'b0;
                end
            end else begin
                do_pop  = (m_q.size() > 0) && rdy;
                do_push = m_run && !hl && ((m_q.size() < DEPTH) || do_pop);
                if (do_pop) void'(m_q.pop_front());
                if (do_push) begin
                    e.ins = mem_word(m_pc);
                    e.pc  = m_pc;
                    m_q.push_back(e);
                    m_pc = m_pc + 64'd4;
                end
            end
            m_run = run_next;
        end

        @(posedge clk);
        #1;
        check("model.valid", inst_valid, 64'(m_q.size() > 0));
        check("model.count", count, 64'(m_q.size()));
        check("model.inst", inst, (m_q.size() > 0) ? 64'(m_q[0].ins) : 64'h0);
        check("model.inst_pc", inst_pc, (m_q.size() > 0) ? m_q[0].pc : 64'h0);
        check("model.imem_addr", imem_addr, m_pc);
        check("model.misalign_err", misalign_err, 64'(m_err));
    endtask

    typedef struct {
        bit          rst, st, hl, rdy, br;
        logic [63:0] bpc, boff;
        bit          ev;
        logic [63:0] epc;
        int          ecnt;
        bit          eerr;
        logic [63:0] eaddr;
    } vec_t;

    function automatic vec_t mk(bit rst, bit st, bit hl, bit rdy, bit br,
                                logic [63:0] bpc, logic [63:0] boff,
                                bit ev, logic [63:0] epc, int ecnt, bit eerr, logic [63:0] eaddr);
        vec_t v;
        v.rst = rst; v.st = st; v.hl = hl; v.rdy = rdy; v.br = br;
        v.bpc = bpc; v.boff = boff; v.ev = ev; v.epc = epc;
        v.ecnt = ecnt; v.eerr = eerr; v.eaddr = eaddr;
        return v;
    endfunction

    vec_t tbl[24];

    initial begin
        // Expected state after each edge
        tbl[0]  = mk(0,0,0,0,0, 0,0,        0,0,    0,0,0);
        tbl[1]  = mk(1,1,0,0,0, 0,0,        0,0,    0,0,0);
        tbl[2]  = mk(1,0,0,0,0, 0,0,        1,0,    1,0,4);
        tbl[3]  = mk(1,0,0,0,0, 0,0,        1,0,    2,0,8);
        tbl[4]  = mk(1,0,0,0,0, 0,0,        1,0,    3,0,12);
        tbl[5]  = mk(1,0,0,0,0, 0,0,        1,0,    4,0,16);
        tbl[6]  = mk(1,0,0,0,0, 0,0,        1,0,    4,0,16);
        tbl[7]  = mk(1,0,0,1,0, 0,0,        1,4,    4,0,20);
        tbl[8]  = mk(1,0,0,1,0, 0,0,        1,8,    4,0,24);
        tbl[9]  = mk(1,0,1,1,0, 0,0,        1,12,   3,0,24);
        tbl[10] = mk(1,1,0,1,1, 'h20,'h10,  0,0,    0,0,'h40);
        tbl[11] = mk(1,0,0,1,0, 0,0,        1,'h40, 1,0,'h44);
        tbl[12] = mk(1,0,0,1,0, 0,0,        1,'h44, 1,0,'h48);
        tbl[13] = mk(1,0,0,1,0, 0,0,        1,'h48, 1,0,'h4c);
        tbl[14] = mk(1,0,0,1,1, 'h20,1,     0,0,    0,1,'h22);
        tbl[15] = mk(1,1,0,1,0, 0,0,        0,0,    0,1,'h22);
        tbl[16] = mk(1,0,0,1,0, 0,0,        0,0,    0,1,'h22);
        tbl[17] = mk(0,0,0,0,0, 0,0,        0,0,    0,0,0);
        tbl[18] = mk(1,1,0,0,0, 0,0,        0,0,    0,0,0);
        tbl[19] = mk(1,0,0,0,0, 0,0,        1,0,    1,0,4);
        tbl[20] = mk(1,0,0,0,0, 0,0,        1,0,    2,0,8);
        tbl[21] = mk(1,0,0,0,0, 0,0,        1,0,    3,0,12);
        tbl[22] = mk(0,0,0,0,0, 0,0,        0,0,    0,0,0);
        tbl[23] = mk(1,0,0,0,0, 0,0,        0,0,    0,0,0);

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].rst, tbl[i].st, tbl[i].hl, tbl[i].rdy, tbl[i].br, tbl[i].bpc, tbl[i].boff);
            check($sformatf("vec%0d.valid", i), inst_valid, 64'(tbl[i].ev));
            check($sformatf("vec%0d.inst_pc", i), inst_pc, tbl[i].epc);
            check($sformatf("vec%0d.inst", i), inst, tbl[i].ev ? 64'(mem_word(tbl[i].epc)) : 64'h0);
            check($sformatf("vec%0d.count", i), count, 64'(tbl[i].ecnt));
            check($sformatf("vec%0d.err", i), misalign_err, 64'(tbl[i].eerr));
            check($sformatf("vec%0d.imem_addr", i), imem_addr, tbl[i].eaddr);
        end

        // Randomized traffic, including wraparound targets and rare misalignment
        step(1'b0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit          r_rst, r_st, r_hl, r_rdy, r_br;
            logic [63:0] r_bpc, r_boff;
            int          off;
            r_rst = ($urandom_range(0, 99) != 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_hl  = ($urandom_range(0, 9) == 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_br  = ($urandom_range(0, 15) == 0);
            r_bpc = {$urandom, $urandom};
            r_bpc[1:0] = 2'b00;
            off    = int'($urandom_range(0, 255)) - 128;
            r_boff = 64'(longint'(off)) << 1;
            if ($urandom_range(0, 7) == 0) r_boff[0] = 1'b1;
            step(r_rst, r_st, r_hl, r_rdy, r_br, r_bpc, r_boff);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
